// File: rtl/run_seq_fsm.sv
// Run-length sequencer: IDLE -> RUN for len cycles -> DONE for DONE_HOLD cycles -> IDLE,
// with abort handling, zero-length rejection, optional DONE->RUN restart and a saturating
// completion counter. All outputs come from registers or decoded registered state.
module run_seq_fsm #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned DONE_HOLD    = 1,
    parameter bit          AUTO_RESTART = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done_pulse,
    output logic             aborted,
    output logic             len_err,
    output logic [CNT_W-1:0] remaining,
    output logic [CNT_W-1:0] done_count
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDone  = 2'd2,
        StAbort = 2'd3
    } state_e;

    // hold_q counts down the DONE cycles still to come after the current one
    localparam logic [3:0]       HoldLast = 4'(DONE_HOLD - 1);
    localparam logic [CNT_W-1:0] CountMax = '1;
    localparam logic [CNT_W-1:0] RemOne   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] done_count_q, done_count_d;
    logic [3:0]       hold_q, hold_d;
    logic             done_pulse_q, done_pulse_d;
    logic             len_err_q, len_err_d;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        done_count_d = done_count_q;
        hold_d       = hold_q;
        done_pulse_d = 1'b0;
        len_err_d    = 1'b0;
        case (state_q)
            StIdle: begin
                remaining_d = '0;
                if (start) begin
                    if (len != '0) begin
                        state_d     = StRun;
                        remaining_d = len;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                // Abort wins over completion on the last RUN cycle
                if (abort) begin
                    state_d     = StAbort;
                    remaining_d = '0;
                end else if (remaining_q == RemOne) begin
                    state_d      = StDone;
                    remaining_d  = '0;
                    hold_d       = HoldLast;
                    done_pulse_d = 1'b1;
                    if (done_count_q != CountMax) begin
                        done_count_d = done_count_q + RemOne;
                    end
                end else begin
                    remaining_d = remaining_q - RemOne;
                end
            end
            StDone: begin
                remaining_d = '0;
                if (hold_q == 4'd0) begin
                    state_d = StIdle;
                    if (AUTO_RESTART && start) begin
                        if (len != '0) begin
                            state_d     = StRun;
                            remaining_d = len;
                        end else begin
                            len_err_d = 1'b1;
                        end
                    end
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            StAbort: begin
                state_d     = StIdle;
                remaining_d = '0;
            end
            default: begin
                state_d     = StIdle;
                remaining_d = '0;
            end
        endcase
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            remaining_q  <= '0;
            done_count_q <= '0;
            hold_q       <= 4'd0;
            done_pulse_q <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            done_count_q <= done_count_d;
            hold_q       <= hold_d;
            done_pulse_q <= done_pulse_d;
            len_err_q    <= len_err_d;
        end
    end

    // Output decode from registered state only
    always_comb begin
        state      = state_q;
        busy       = (state_q != StIdle);
        aborted    = (state_q == StAbort);
        done_pulse = done_pulse_q;
        len_err    = len_err_q;
        remaining  = remaining_q;
        done_count = done_count_q;
    end

endmodule

// File: tb/tb_run_seq_fsm.sv
// Directed table-driven bench for run_seq_fsm: default instance, auto-restart instance
// (DONE_HOLD=2) and a CNT_W=2 instance for counter saturation.
module tb_run_seq_fsm;

    typedef struct {
        int         sel;
        logic       start;
        logic [7:0] len;
        logic       abort;
        logic [1:0] st;
        logic [7:0] rem;
        logic       dp;
        logic       ab;
        logic       le;
        logic       busy;
        logic [7:0] dc;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic       in_start [2];
    logic [7:0] in_len   [2];
    logic       in_abort [2];
    logic [1:0] o_state  [2];
    logic       o_busy   [2];
    logic       o_dp     [2];
    logic       o_ab     [2];
    logic       o_le     [2];
    logic [7:0] o_rem    [2];
    logic [7:0] o_dc     [2];

    logic       s_start, s_abort;
    logic [1:0] s_len, s_state, s_rem, s_dc;
    logic       s_busy, s_dp, s_ab, s_le;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    run_seq_fsm #(.CNT_W(8), .DONE_HOLD(1), .AUTO_RESTART(1'b0)) u_dflt (
        .clk(clk), .reset(reset), .start(in_start[0]), .len(in_len[0]), .abort(in_abort[0]),
        .state(o_state[0]), .busy(o_busy[0]), .done_pulse(o_dp[0]), .aborted(o_ab[0]),
        .len_err(o_le[0]), .remaining(o_rem[0]), .done_count(o_dc[0])
    );

    run_seq_fsm #(.CNT_W(8), .DONE_HOLD(2), .AUTO_RESTART(1'b1)) u_auto (
        .clk(clk), .reset(reset), .start(in_start[1]), .len(in_len[1]), .abort(in_abort[1]),
        .state(o_state[1]), .busy(o_busy[1]), .done_pulse(o_dp[1]), .aborted(o_ab[1]),
        .len_err(o_le[1]), .remaining(o_rem[1]), .done_count(o_dc[1])
    );

    run_seq_fsm #(.CNT_W(2), .DONE_HOLD(1), .AUTO_RESTART(1'b0)) u_sat (
        .clk(clk), .reset(reset), .start(s_start), .len(s_len), .abort(s_abort),
        .state(s_state), .busy(s_busy), .done_pulse(s_dp), .aborted(s_ab),
        .len_err(s_le), .remaining(s_rem), .done_count(s_dc)
    );

    function automatic vec_t mk(int sel, logic start, logic [7:0] len, logic abort,
                                logic [1:0] st, logic [7:0] rem, logic dp, logic ab,
                                logic le, logic busy, logic [7:0] dc);
        vec_t v;
        v.sel = sel; v.start = start; v.len = len; v.abort = abort;
        v.st = st; v.rem = rem; v.dp = dp; v.ab = ab; v.le = le; v.busy = busy; v.dc = dc;
        return v;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // sel 0/1 drive the 8-bit instances, sel 2 the CNT_W=2 instance; one clock per step
    task automatic step(int sel, logic start, logic [7:0] len, logic abort);
        for (int i = 0; i < 2; i++) begin
            in_start[i] = 1'b0; in_len[i] = 8'd0; in_abort[i] = 1'b0;
        end
        s_start = 1'b0; s_len = 2'd0; s_abort = 1'b0;
        if (sel == 2) begin
            s_start = start; s_len = len[1:0]; s_abort = abort;
        end else begin
            in_start[sel] = start; in_len[sel] = len; in_abort[sel] = abort;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(string tag, int sel, logic [1:0] st, logic [7:0] rem, logic dp,
                           logic ab, logic le, logic busy, logic [7:0] dc);
        chk({tag, ".state"}, 8'(o_state[sel]), 8'(st));
        chk({tag, ".remaining"}, o_rem[sel], rem);
        chk({tag, ".done_pulse"}, 8'(o_dp[sel]), 8'(dp));
        chk({tag, ".aborted"}, 8'(o_ab[sel]), 8'(ab));
        chk({tag, ".len_err"}, 8'(o_le[sel]), 8'(le));
        chk({tag, ".busy"}, 8'(o_busy[sel]), 8'(busy));
        chk({tag, ".done_count"}, o_dc[sel], dc);
    endtask

    initial begin
        // Default instance: nominal run (start ignored mid-run), zero length, abort,
        // abort on last RUN cycle, abort in IDLE, start/abort ignored in DONE
        vecs.push_back(mk(0, 1, 3, 0, 1, 3, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 7, 0, 1, 2, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 5, 0, 1, 5, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3, 0, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 2, 0, 1, 2, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3, 0, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 2, 0, 1, 0, 0, 1, 2));
        vecs.push_back(mk(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        // Auto-restart instance (DONE_HOLD=2)
        vecs.push_back(mk(1, 1, 2, 0, 1, 2, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 2, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 5, 0, 2, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 2, 0, 1, 2, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 2, 0, 1, 0, 0, 1, 2));
        vecs.push_back(mk(1, 0, 0, 1, 2, 0, 0, 0, 0, 1, 2));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 0, 0, 0, 1, 2));
        vecs.push_back(mk(1, 0, 0, 0, 2, 0, 1, 0, 0, 1, 3));
        vecs.push_back(mk(1, 0, 0, 0, 2, 0, 0, 0, 0, 1, 3));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));

        // Reset with start asserted must still leave everything idle
        reset = 1'b1;
        step(0, 1, 8'd3, 0);
        step(1, 1, 8'd3, 0);
        chk_all("reset0", 0, 2'd0, 8'd0, 0, 0, 0, 0, 8'd0);
        chk_all("reset1", 1, 2'd0, 8'd0, 0, 0, 0, 0, 8'd0);
        chk("reset2.state", 8'(s_state), 8'd0);
        chk("reset2.done_count", 8'(s_dc), 8'd0);
        reset = 1'b0;

        // First row starts on the first edge after reset release
        foreach (vecs[i]) begin
            step(vecs[i].sel, vecs[i].start, vecs[i].len, vecs[i].abort);
            chk_all($sformatf("row%0d", i), vecs[i].sel, vecs[i].st, vecs[i].rem, vecs[i].dp,
                    vecs[i].ab, vecs[i].le, vecs[i].busy, vecs[i].dc);
        end

        // Reset mid-run beats start and abort, then start is accepted right away
        step(0, 1, 8'd9, 0);
        chk("midrun.rem9", o_rem[0], 8'd9);
        step(0, 0, 8'd0, 0);
        chk("midrun.rem8", o_rem[0], 8'd8);
        reset = 1'b1;
        step(0, 1, 8'd4, 1);
        chk_all("midrun.reset", 0, 2'd0, 8'd0, 0, 0, 0, 0, 8'd0);
        reset = 1'b0;
        step(0, 1, 8'd2, 0);
        chk_all("after_reset", 0, 2'd1, 8'd2, 0, 0, 0, 1, 8'd0);

        // CNT_W=2: four completed runs saturate done_count at 3
        for (int r = 0; r < 4; r++) begin
            step(2, 1, 8'd1, 0);
            chk($sformatf("sat%0d.run", r), 8'(s_state), 8'd1);
            step(2, 0, 8'd0, 0);
            chk($sformatf("sat%0d.done", r), 8'(s_state), 8'd2);
            chk($sformatf("sat%0d.done_pulse", r), 8'(s_dp), 8'd1);
            chk($sformatf("sat%0d.done_count", r), 8'(s_dc), (r < 3) ? 8'(r + 1) : 8'd3);
            step(2, 0, 8'd0, 0);
            chk($sformatf("sat%0d.idle", r), 8'(s_state), 8'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
